// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Writeback arbiter between the two result producers (EX/ALU and LSU) and
//   the single write port of the general-purpose register file.
//   Each producer has a one-entry buffer. One buffered result is granted per
//   cycle, round-robin when both buffers hold a result. Writes to x0 are
//   consumed without touching the register file. Per-register busy bits track
//   pending writes for the issue stage's RAW-hazard check.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid/ex_ready          EX result handshake
//   ex_waddr/ex_wdata          EX destination register / result data
//   ls_valid/ls_ready          LSU result handshake
//   ls_waddr/ls_wdata          LSU destination register / load data
//   issue_en/issue_rd          issue stage dispatched an instruction writing rd
//   busy                       per-register pending-write bits (bit 0 is 0)
//   rf_wen/rf_waddr/rf_wdata   register-file write port
//   wb_count                   committed non-x0 writes, wraps at 2^32
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  logic [ADDR_WIDTH-1:0]        ex_waddr,
    input  logic [DATA_WIDTH-1:0]        ex_wdata,
    input  logic                         ls_valid,
    output logic                         ls_ready,
    input  logic [ADDR_WIDTH-1:0]        ls_waddr,
    input  logic [DATA_WIDTH-1:0]        ls_wdata,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    output logic [(2**ADDR_WIDTH)-1:0]   busy,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic [31:0]                  wb_count
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    // One-entry result buffers
    logic                    r_ex_full;
    logic [ADDR_WIDTH-1:0]   r_ex_addr;
    logic [DATA_WIDTH-1:0]   r_ex_data;
    logic                    r_ls_full;
    logic [ADDR_WIDTH-1:0]   r_ls_addr;
    logic [DATA_WIDTH-1:0]   r_ls_data;

    // Round-robin pointer: 1 = LS was granted last, so EX wins the next tie.
    logic                    r_rr_last_ls;

    logic [NUM_REGS-1:0]     r_busy;
    logic [NUM_REGS-1:0]     w_busy_next;
    logic [31:0]             r_wb_count;

    logic                    w_grant_ex;
    logic                    w_grant_ls;
    logic                    w_ex_accept;
    logic                    w_ls_accept;

    // ------------------------------------------------------------------
    // Grant: a lone full entry always wins; on a tie the source that was
    // not granted last wins.
    // ------------------------------------------------------------------
    assign w_grant_ex = r_ex_full & (~r_ls_full | r_rr_last_ls);
    assign w_grant_ls = r_ls_full & (~r_ex_full | ~r_rr_last_ls);

    // A buffer being drained this cycle can be refilled on the same edge,
    // which is what gives one write per cycle under sustained load.
    assign ex_ready    = ~r_ex_full | w_grant_ex;
    assign ls_ready    = ~r_ls_full | w_grant_ls;
    assign w_ex_accept = ex_valid & ex_ready;
    assign w_ls_accept = ls_valid & ls_ready;

    // ------------------------------------------------------------------
    // EX buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_full <= 1'b0;
            r_ex_addr <= '0;
            r_ex_data <= '0;
        end else if (w_ex_accept) begin
            r_ex_full <= 1'b1;
            r_ex_addr <= ex_waddr;
            r_ex_data <= ex_wdata;
        end else if (w_grant_ex) begin
            r_ex_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // LSU buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ls_full <= 1'b0;
            r_ls_addr <= '0;
            r_ls_data <= '0;
        end else if (w_ls_accept) begin
            r_ls_full <= 1'b1;
            r_ls_addr <= ls_waddr;
            r_ls_data <= ls_wdata;
        end else if (w_grant_ls) begin
            r_ls_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer, updated on every grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last_ls <= 1'b1;
        end else if (w_grant_ex) begin
            r_rr_last_ls <= 1'b0;
        end else if (w_grant_ls) begin
            r_rr_last_ls <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write port: combinational from the granted entry. An x0 entry is
    // granted (and so consumed) but never raises rf_wen.
    // ------------------------------------------------------------------
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_grant_ex) begin
            rf_wen   = (r_ex_addr != '0);
            rf_waddr = r_ex_addr;
            rf_wdata = r_ex_data;
        end else if (w_grant_ls) begin
            rf_wen   = (r_ls_addr != '0);
            rf_waddr = r_ls_addr;
            rf_wdata = r_ls_data;
        end
    end

    // ------------------------------------------------------------------
    // Busy bits. A new issue to a register has priority over the commit of
    // the previous write to it, so the new pending write stays visible.
    // ------------------------------------------------------------------
    assign w_busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = issue_en & (issue_rd == ADDR_WIDTH'(gi));
            assign w_clr = rf_wen & (rf_waddr == ADDR_WIDTH'(gi));
            assign w_busy_next[gi] = w_set | (r_busy[gi] & ~w_clr);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy = r_busy;

    // ------------------------------------------------------------------
    // Committed-write counter (wraps naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_count <= '0;
        end else if (rf_wen) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed bench for wb_arbiter. Stimulus pushes each expected register
//   write (address, data) into a queue in the order the arbiter must grant
//   it; a forked monitor pops and compares on every cycle with rf_wen high.
//   Handshake, busy and counter values are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ex_valid;
    logic           ex_ready;
    logic [AW-1:0]  ex_waddr;
    logic [DW-1:0]  ex_wdata;
    logic           ls_valid;
    logic           ls_ready;
    logic [AW-1:0]  ls_waddr;
    logic [DW-1:0]  ls_wdata;
    logic           issue_en;
    logic [AW-1:0]  issue_rd;
    logic [31:0]    busy;
    logic           rf_wen;
    logic [AW-1:0]  rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic [31:0]    wb_count;

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_waddr (ex_waddr),
        .ex_wdata (ex_wdata),
        .ls_valid (ls_valid),
        .ls_ready (ls_ready),
        .ls_waddr (ls_waddr),
        .ls_wdata (ls_wdata),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .busy     (busy),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        check(name, {31'd0, act}, {31'd0, req});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [31:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    task automatic monitor();
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rf_wen) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got x%0d=0x%08h, required no write",
                             rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_addr", 32'(rf_waddr), 32'(e[AW+DW-1:DW]));
                    check("wb_data", rf_wdata, e[DW-1:0]);
                end
            end
        end
    endtask

    initial begin
        int ei;
        int li;
        int cyc;
        logic acc_e;
        logic acc_l;

        ex_valid = 1'b0; ex_waddr = '0; ex_wdata = '0;
        ls_valid = 1'b0; ls_waddr = '0; ls_wdata = '0;
        issue_en = 1'b0; issue_rd = '0;
        fork
            monitor();
        join_none

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1("rst_rf_wen", rf_wen, 1'b0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_wb_count", wb_count, 32'd0);
        chk1("rst_ex_ready", ex_ready, 1'b1);
        chk1("rst_ls_ready", ls_ready, 1'b1);

        // ---------------- tie: EX wins first after reset ----------------
        ex_valid = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h11;
        ls_valid = 1'b1; ls_waddr = 5'd2; ls_wdata = 32'h22;
        push(1, 32'h11);
        push(2, 32'h22);
        tick();
        ex_valid = 1'b0; ls_valid = 1'b0;
        chk1("tie_ex_ready", ex_ready, 1'b1);
        chk1("tie_ls_ready", ls_ready, 1'b0);
        tick();
        chk1("tie2_ls_ready", ls_ready, 1'b1);
        chk1("tie2_rf_wen", rf_wen, 1'b1);
        tick();
        chk1("tie_drained", rf_wen, 1'b0);
        check("tie_wb_count", wb_count, 32'd2);

        // ---------------- EX only ----------------
        ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        tick();
        ex_valid = 1'b0;
        chk1("ex_only_rf_wen", rf_wen, 1'b1);
        tick();
        check("ex_only_wb_count", wb_count, 32'd3);

        // ---------------- sustained: EX granted last, so LS leads ----------------
        for (int i = 0; i < 4; i++) begin
            push(16 + i, 32'h5000_0000 + 32'(i));
            push(8 + i, 32'hE000_0000 + 32'(i));
        end
        ei = 0; li = 0; cyc = 0;
        while ((ei < 4 || li < 4) && cyc < 40) begin
            ex_valid = (ei < 4); ex_waddr = AW'(8 + ei);  ex_wdata = 32'hE000_0000 + 32'(ei);
            ls_valid = (li < 4); ls_waddr = AW'(16 + li); ls_wdata = 32'h5000_0000 + 32'(li);
            if (cyc > 0) chk1("stream_rf_wen", rf_wen, 1'b1);
            acc_e = ex_valid & ex_ready;
            acc_l = ls_valid & ls_ready;
            tick();
            cyc++;
            if (acc_e) ei++;
            if (acc_l) li++;
        end
        ex_valid = 1'b0; ls_valid = 1'b0;
        chk1("stream_done", (ei == 4) && (li == 4), 1'b1);
        check("stream_cycles", 32'(cyc), 32'd7);
        chk1("stream_rf_wen_7", rf_wen, 1'b1);
        tick();
        chk1("stream_rf_wen_8", rf_wen, 1'b1);
        tick();
        chk1("stream_idle", rf_wen, 1'b0);
        check("stream_wb_count", wb_count, 32'd11);

        // ---------------- x0 write consumed silently ----------------
        ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'h1234;
        tick();
        ex_valid = 1'b0;
        chk1("x0_rf_wen", rf_wen, 1'b0);
        chk1("x0_ex_ready", ex_ready, 1'b1);
        tick();
        chk1("x0_ex_ready_after", ex_ready, 1'b1);
        check("x0_wb_count", wb_count, 32'd11);
        check("x0_busy", busy, 32'd0);

        // ---------------- busy tracking ----------------
        issue_en = 1'b1; issue_rd = 5'd0;
        tick();
        check("busy_issue_x0", busy, 32'd0);
        issue_rd = 5'd7;
        tick();
        issue_en = 1'b0;
        check("busy_set", busy, 32'h80);
        ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h77;
        push(7, 32'h77);
        tick();
        ex_valid = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd7;
        chk1("busy_commit_rf_wen", rf_wen, 1'b1);
        tick();
        issue_en = 1'b0;
        check("busy_set_wins", busy, 32'h80);
        ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h78;
        push(7, 32'h78);
        tick();
        ex_valid = 1'b0;
        tick();
        check("busy_clear", busy, 32'd0);
        check("busy_wb_count", wb_count, 32'd13);

        // ---------------- reset mid-operation ----------------
        issue_en = 1'b1; issue_rd = 5'd7;
        ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h33;
        ls_valid = 1'b1; ls_waddr = 5'd4; ls_wdata = 32'h44;
        tick();
        issue_en = 1'b0; ex_valid = 1'b0; ls_valid = 1'b0;
        check("pre_rst_busy", busy, 32'h80);
        chk1("pre_rst_ex_ready", ex_ready, 1'b0);
        check("pre_rst_rf_waddr", 32'(rf_waddr), 32'd4);
        rst_n = 1'b0;
        #1;
        chk1("in_rst_rf_wen", rf_wen, 1'b0);
        check("in_rst_busy", busy, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk1("post_rst_ex_ready", ex_ready, 1'b1);
        chk1("post_rst_ls_ready", ls_ready, 1'b1);
        check("post_rst_wb_count", wb_count, 32'd0);
        chk1("post_rst_rf_wen", rf_wen, 1'b0);
        tick();
        chk1("post_rst_idle", rf_wen, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
